// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, FSM state encoding (common with the receiver)
// and the default bit period for a 50 MHz clock at 9600 baud.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period clock-enable generator: counts 0..CLKS_PER_BIT-1 while enabled and
// raises o_tick in the last cycle of each period before wrapping to zero.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  assign o_tick = i_enable && (r_count == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_tick ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8-N-1 UART transmitter with optional second stop bit and a valid/ready byte input.
// The TX line is a register driven from the next-state logic, so it never glitches.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [UART_DATA_BITS-1:0] i_tx_data,
  input  logic                      i_tx_valid,
  output logic                      o_tx_ready,
  output logic                      o_tx,
  output logic                      o_tx_done,
  output logic                      o_tx_busy
);

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);

  uart_state_e               r_state, w_state_next;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
  logic [2:0]                r_bit_idx, w_bit_idx_next;
  logic                      r_stop_idx, w_stop_idx_next;
  logic                      r_tx, w_tx_next;
  logic                      r_ready;
  logic                      w_tick;
  logic                      w_handshake;
  logic                      w_busy;
  logic                      w_done;

  assign w_handshake = i_tx_valid && r_ready;
  assign w_busy      = (r_state != IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_handshake),
    .i_enable(w_busy),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    w_done          = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_handshake) begin
          w_state_next    = START;
          w_shift_next    = i_tx_data;
          w_bit_idx_next  = '0;
          w_stop_idx_next = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next   = DATA;
          w_bit_idx_next = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == LAST_BIT) begin
            w_state_next    = STOP;
            w_stop_idx_next = 1'b0;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_stop_idx == LAST_STOP) begin
            w_done       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_stop_idx_next = r_stop_idx + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Line level is derived from where we will be, so the register leads the state by zero cycles.
    unique case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
      r_tx       <= w_tx_next;
      r_ready    <= (w_state_next == IDLE);
    end
  end

  assign o_tx       = r_tx;
  assign o_tx_ready = r_ready;
  assign o_tx_done  = w_done;
  assign o_tx_busy  = w_busy;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: one instance with one stop bit, one with two,
// both at 16 clocks per bit, checked cycle by cycle against hand-derived frames.
module tb_uart_transmitter;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] txData1, txData2;
  logic       txValid1, txValid2;
  logic       tx1, ready1, done1, busy1;
  logic       tx2, ready2, done2, busy2;

  int numCompared   = 0;
  int numMismatched = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .i_clk(clk), .i_rst_n(rstN), .i_tx_data(txData1), .i_tx_valid(txValid1),
    .o_tx_ready(ready1), .o_tx(tx1), .o_tx_done(done1), .o_tx_busy(busy1)
  );

  uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst_n(rstN), .i_tx_data(txData2), .i_tx_valid(txValid2),
    .o_tx_ready(ready2), .o_tx(tx2), .o_tx_done(done2), .o_tx_busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    assert (observed === expected) else begin
      numMismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a byte while the DUT is idle; the next edge is the handshake.
  task automatic applyStimulus(input int dutSel, input logic [7:0] data, input bit holdValid);
    if (dutSel == 2) begin
      txData2 = data; txValid2 = 1'b1;
      checkOutput("hs_ready_d2", {31'd0, ready2}, 32'd1);
    end else begin
      txData1 = data; txValid1 = 1'b1;
      checkOutput("hs_ready_d1", {31'd0, ready1}, 32'd1);
    end
    tick();
    if (!holdValid) begin
      if (dutSel == 2) txValid2 = 1'b0;
      else             txValid1 = 1'b0;
    end
  endtask

  // Starting in the first cycle after the handshake, checks every cycle of the frame
  // plus the following idle cycle, and decodes the byte by mid-bit sampling.
  task automatic observeFrame(input int dutSel, input logic [7:0] data, input int stopBits,
                              input string name, input bit changeData, input logic [7:0] newData);
    int         frameLen;
    logic [7:0] decoded;
    logic       oTx, oDone, oReady, oBusy, expTx;
    frameLen = (9 + stopBits) * CPB;
    decoded  = 8'h00;
    for (int k = 1; k <= frameLen + 1; k++) begin
      oTx    = (dutSel == 2) ? tx2    : tx1;
      oDone  = (dutSel == 2) ? done2  : done1;
      oReady = (dutSel == 2) ? ready2 : ready1;
      oBusy  = (dutSel == 2) ? busy2  : busy1;
      if (k <= CPB)          expTx = 1'b0;
      else if (k <= 9 * CPB) expTx = data[(k - CPB - 1) / CPB];
      else                   expTx = 1'b1;
      checkOutput($sformatf("%s_tx_c%0d", name, k),    {31'd0, oTx},    {31'd0, expTx});
      checkOutput($sformatf("%s_done_c%0d", name, k),  {31'd0, oDone},  {31'd0, (k == frameLen)});
      checkOutput($sformatf("%s_ready_c%0d", name, k), {31'd0, oReady}, {31'd0, (k == frameLen + 1)});
      checkOutput($sformatf("%s_busy_c%0d", name, k),  {31'd0, oBusy},  {31'd0, (k <= frameLen)});
      if (k > CPB && k <= 9 * CPB && ((k - CPB) % CPB) == CPB / 2)
        decoded[(k - CPB - 1) / CPB] = oTx;
      if (k == 1 && changeData) begin
        if (dutSel == 2) txData2 = newData;
        else             txData1 = newData;
      end
      if (k <= frameLen) tick();
    end
    checkOutput($sformatf("%s_decode", name), {24'd0, decoded}, {24'd0, data});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    txData1 = 8'h00; txData2 = 8'h00;
    txValid1 = 1'b0; txValid2 = 1'b0;

    // Reset held for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("rst_tx1",    {31'd0, tx1},    32'd1);
      checkOutput("rst_tx2",    {31'd0, tx2},    32'd1);
      checkOutput("rst_ready1", {31'd0, ready1}, 32'd0);
      checkOutput("rst_ready2", {31'd0, ready2}, 32'd0);
      checkOutput("rst_done1",  {31'd0, done1},  32'd0);
      checkOutput("rst_busy1",  {31'd0, busy1},  32'd0);
    end
    rstN = 1'b1;
    #1;
    checkOutput("rel_ready_pre", {31'd0, ready1}, 32'd0);
    tick();
    checkOutput("rel_ready1", {31'd0, ready1}, 32'd1);
    checkOutput("rel_ready2", {31'd0, ready2}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idle_tx1",   {31'd0, tx1},   32'd1);
      checkOutput("idle_done1", {31'd0, done1}, 32'd0);
    end

    // Single byte 0xA5.
    applyStimulus(1, 8'hA5, 1'b0);
    observeFrame(1, 8'hA5, 1, "a5", 1'b0, 8'h00);

    // Back-to-back 0x00 then 0xFF with valid held; second handshake in the idle cycle.
    applyStimulus(1, 8'h00, 1'b1);
    observeFrame(1, 8'h00, 1, "b2b00", 1'b1, 8'hFF);
    tick();
    txValid1 = 1'b0;
    observeFrame(1, 8'hFF, 1, "b2bFF", 1'b0, 8'h00);

    // Two stop bits on the second instance.
    applyStimulus(2, 8'h3C, 1'b0);
    observeFrame(2, 8'h3C, 2, "sb2", 1'b0, 8'h00);

    // Input data changing right after the handshake must not affect the frame.
    applyStimulus(1, 8'h81, 1'b0);
    observeFrame(1, 8'h81, 1, "stab", 1'b1, 8'h11);

    // Reset in the middle of data bit 4 of 0x55.
    applyStimulus(1, 8'h55, 1'b0);
    for (int k = 1; k < 88; k++) tick();
    checkOutput("mid_busy_pre", {31'd0, busy1}, 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("mid_tx",    {31'd0, tx1},    32'd1);
    checkOutput("mid_busy",  {31'd0, busy1},  32'd0);
    checkOutput("mid_ready", {31'd0, ready1}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("mid_rst_done", {31'd0, done1}, 32'd0);
      checkOutput("mid_rst_tx",   {31'd0, tx1},   32'd1);
    end
    rstN = 1'b1;
    #1;
    checkOutput("mid_rel_ready_pre", {31'd0, ready1}, 32'd0);
    tick();
    checkOutput("mid_rel_ready", {31'd0, ready1}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      checkOutput("mid_post_done", {31'd0, done1}, 32'd0);
      checkOutput("mid_post_tx",   {31'd0, tx1},   32'd1);
      tick();
    end
    applyStimulus(1, 8'h55, 1'b0);
    observeFrame(1, 8'h55, 1, "r55", 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises one byte per request onto a UART line in 8-N-1 format, with an optional second stop bit.
- Companion to the existing UART receiver. It drives the TX pin at the configured baud rate from a single system clock.
- Upstream logic hands bytes over with a valid/ready handshake.
- Bit timing comes from an internal clock-enable counter, not a derived clock.

Parameters:
- CLKS_PER_BIT, 5208: system clocks per UART bit (50 MHz / 9600 baud); legal range 4..65535.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  asynchronous, active-low reset. Asserting it (0) resets immediately; release is synchronised by the integrator.
- TX_DATA  input  8  byte to send; sampled only on handshake.
- TX_VALID  input  1  upstream has a byte on TX_DATA.
- TX_READY  output  1  block can accept a byte this cycle.
- TX  output  1  serial line; idle high.
- TX_DONE  output  1  one-cycle pulse in the final cycle of the last stop bit.
- TX_BUSY  output  1  high while a frame is in progress (START, DATA or STOP).

Behaviour:
- Reset values: TX=1, TX_READY=0 while RST=0, TX_DONE=0, TX_BUSY=0. State=IDLE, counters=0, shift register=0.
- TX_READY = 1 exactly when state==IDLE and RST deasserted. It is registered/combinational from state only and never depends on TX_VALID.
- Handshake: transfer occurs on a posedge with TX_VALID=1 and TX_READY=1.
  - On that edge: TX_DATA latched into the shift register, baud counter cleared, state goes to START.
  - TX_DATA changes after the handshake have no effect on the frame.
- Latency: TX falls on the clock edge that accepts the byte, so TX reads 0 in the cycle after the handshake.
- Baud counter: counts 0..CLKS_PER_BIT-1. A bit_tick is asserted when count==CLKS_PER_BIT-1; the counter then wraps to 0. Each bit therefore lasts exactly CLKS_PER_BIT cycles.
- States:
  - IDLE: TX=1. Goes to START on handshake.
  - START: TX=0 for one bit time. On bit_tick goes to DATA with bit_idx=0.
  - DATA: TX=shift[0], LSB first. On bit_tick the register shifts right and bit_idx increments. On bit_tick with bit_idx==7, goes to STOP with stop_idx=0.
  - STOP: TX=1. On bit_tick:
    - if stop_idx==STOP_BITS-1, assert TX_DONE for that same cycle and go to IDLE;
    - else increment stop_idx.
- Frame length: (1 + 8 + STOP_BITS) × CLKS_PER_BIT cycles, from the first TX=0 cycle to the IDLE re-entry.
- Back-to-back: if TX_VALID is held high, the next handshake happens in the first IDLE cycle, one cycle after TX_DONE. The stop bit is never shortened; the line shows exactly STOP_BITS×CLKS_PER_BIT high cycles plus one IDLE cycle.
- TX is registered and glitch-free; it changes only on posedge CLK.
- Reset mid-frame: TX goes to 1 asynchronously, all state is cleared, and the partial frame is abandoned with no TX_DONE. After release the block is in IDLE, and TX_READY rises on the first clock after release.
- TX_VALID deasserting mid-frame has no effect.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_BITS=8;
  - the state encoding IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3, shared with the receiver for debug visibility;
  - the default CLKS_PER_BIT constant for 50 MHz/9600.
- One sub-module: uart_baud_tick.
  - Parameter CLKS_PER_BIT; inputs CLK, RST, clear, enable; output tick.
  - The receiver can reuse it later in place of its divided clock.

Test Plan:
- Reset and idle (CLKS_PER_BIT=16): hold RST=0 for 5 cycles, release. Expect TX=1, TX_DONE=0 throughout, and TX_READY=1 from the first clock after release.
- Single byte 0xA5: handshake at cycle T. Expect:
  - TX=0 for cycles T+1..T+16;
  - then bits 1,0,1,0,0,1,0,1 each 16 cycles;
  - stop=1 for 16 cycles;
  - TX_DONE high only in cycle T+160;
  - TX_READY=0 from T+1 to T+160.
- Back-to-back 0x00 then 0xFF with TX_VALID held: second start bit begins exactly 161 cycles after the first. The 0xFF frame shows 9 high bit-times (data + stop); the receiver model decodes 0x00, 0xFF.
- STOP_BITS=2 with byte 0x3C: stop-high lasts 32 cycles, total frame is 176 cycles, and TX_DONE fires once.
- Data stability: change TX_DATA to 0x11 one cycle after handshaking 0x81. The transmitted frame must still decode as 0x81.
- Reset mid-frame: assert RST during bit 4 of 0x55. TX goes to 1 within the same cycle, and no TX_DONE occurs. After release, send 0x55 and verify a clean full frame.
